// File: rtl/if_id_skid.sv
// IF->ID boundary register with optional skid entry: accepted pair shows on dn_* the edge it is taken, no bypass.
// Backpressure: SKID=1 drives up_ready_o from the skid-full flag only; SKID=0 passes dn_ready_i through combinationally.
module if_id_skid #(
  parameter int                 PC_W         = 32,
  parameter int                 INST_W       = 32,
  parameter bit                 SKID         = 1'b1,
  parameter bit                 BUBBLE_VALID = 1'b1,
  parameter logic [INST_W-1:0]  NOP_INST     = INST_W'(32'h03400000)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [PC_W-1:0]   up_pc_i,
  input  logic [INST_W-1:0] up_inst_i,
  input  logic              flush_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [PC_W-1:0]   dn_pc_o,
  output logic [INST_W-1:0] dn_inst_o,
  output logic [1:0]        occ_o
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic            m_vld;
  entry_t          m_dat;
  logic            s_vld;
  entry_t          s_dat;
  logic [PC_W-1:0] last_pc;
  entry_t          up_dat;
  logic            up_fire;
  logic            dn_fire;

  assign up_dat     = '{pc: up_pc_i, inst: up_inst_i};
  assign up_ready_o = SKID ? ~s_vld : (~m_vld | dn_ready_i);
  assign up_fire    = up_valid_i & up_ready_o;
  assign dn_fire    = m_vld & dn_ready_i;

  assign dn_valid_o = m_vld;
  assign dn_pc_o    = m_dat.pc;
  assign dn_inst_o  = m_dat.inst;
  assign occ_o      = {1'b0, m_vld} + {1'b0, s_vld};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_vld   <= 1'b0;
      m_dat   <= '0;
      s_vld   <= 1'b0;
      s_dat   <= '0;
      last_pc <= '0;
    end else if (flush_i) begin
      // Flush beats any handshake: the incoming pair is dropped and last_pc is left alone.
      s_vld <= 1'b0;
      if (BUBBLE_VALID) begin
        m_vld <= 1'b1;
        m_dat <= '{pc: last_pc, inst: NOP_INST};
      end else begin
        m_vld <= 1'b0;
      end
    end else begin
      if (up_fire) last_pc <= up_pc_i;
      if (!SKID) begin
        if (up_fire) begin
          m_vld <= 1'b1;
          m_dat <= up_dat;
        end else if (dn_fire) begin
          m_vld <= 1'b0;
        end
      end else if (s_vld) begin
        // Skid full means up_ready_o is low, so nothing new can arrive here.
        if (dn_fire) begin
          m_dat <= s_dat;
          s_vld <= 1'b0;
        end
      end else if (!m_vld || dn_fire) begin
        m_vld <= up_fire;
        if (up_fire) m_dat <= up_dat;
      end else if (up_fire) begin
        s_vld <= 1'b1;
        s_dat <= up_dat;
      end
    end
  end

endmodule

// File: tb/tb_if_id_skid.sv
// Drives three if_id_skid variants with shared stimulus and compares each against an ordered-list model.
module tb_if_id_skid;

  localparam logic [31:0] NOP = 32'h03400000;
  localparam bit SK [3] = '{1'b1, 1'b1, 1'b0};
  localparam bit BV [3] = '{1'b1, 1'b0, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, up_vld, flush, dn_rdy;
  logic [31:0] up_pc, up_inst;
  logic [2:0]  up_rdy, dn_vld;
  logic [31:0] dn_pc [3];
  logic [31:0] dn_inst [3];
  logic [1:0]  occ [3];

  int total = 0;
  int bad   = 0;

  // Model: per variant, an in-order list of held {pc, inst} pairs plus the last accepted PC.
  logic [63:0] mbuf [3][2];
  int          mcnt [3];
  logic [31:0] mlast [3];

  if_id_skid #(.SKID(1'b1), .BUBBLE_VALID(1'b1)) u_dut_sb (
    .clk_i(clk), .rst_i(rst), .up_valid_i(up_vld), .up_ready_o(up_rdy[0]),
    .up_pc_i(up_pc), .up_inst_i(up_inst), .flush_i(flush), .dn_valid_o(dn_vld[0]),
    .dn_ready_i(dn_rdy), .dn_pc_o(dn_pc[0]), .dn_inst_o(dn_inst[0]), .occ_o(occ[0]));

  if_id_skid #(.SKID(1'b1), .BUBBLE_VALID(1'b0)) u_dut_sn (
    .clk_i(clk), .rst_i(rst), .up_valid_i(up_vld), .up_ready_o(up_rdy[1]),
    .up_pc_i(up_pc), .up_inst_i(up_inst), .flush_i(flush), .dn_valid_o(dn_vld[1]),
    .dn_ready_i(dn_rdy), .dn_pc_o(dn_pc[1]), .dn_inst_o(dn_inst[1]), .occ_o(occ[1]));

  if_id_skid #(.SKID(1'b0), .BUBBLE_VALID(1'b1)) u_dut_rb (
    .clk_i(clk), .rst_i(rst), .up_valid_i(up_vld), .up_ready_o(up_rdy[2]),
    .up_pc_i(up_pc), .up_inst_i(up_inst), .flush_i(flush), .dn_valid_o(dn_vld[2]),
    .dn_ready_i(dn_rdy), .dn_pc_o(dn_pc[2]), .dn_inst_o(dn_inst[2]), .occ_o(occ[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs at negedge, check all variants, then advance the model at posedge.
  task automatic step(input logic r, input logic uv, input logic [31:0] pc, input logic [31:0] inst,
                      input logic fl, input logic dr);
    logic uf [3];
    logic df [3];
    logic er;
    @(negedge clk);
    rst = r; up_vld = uv; up_pc = pc; up_inst = inst; flush = fl; dn_rdy = dr;
    #1;
    for (int i = 0; i < 3; i++) begin
      er = SK[i] ? (mcnt[i] < 2) : (mcnt[i] == 0 || dr);
      chk($sformatf("rdy%0d", i), 64'(up_rdy[i]), 64'(er));
      chk($sformatf("vld%0d", i), 64'(dn_vld[i]), 64'(mcnt[i] > 0));
      chk($sformatf("occ%0d", i), 64'(occ[i]), 64'(mcnt[i]));
      if (mcnt[i] > 0) chk($sformatf("dat%0d", i), {dn_pc[i], dn_inst[i]}, mbuf[i][0]);
      uf[i] = uv && er;
      df[i] = (mcnt[i] > 0) && dr;
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        mcnt[i] = 0; mlast[i] = '0;
      end else if (fl) begin
        mcnt[i] = 0;
        if (BV[i]) begin mbuf[i][0] = {mlast[i], NOP}; mcnt[i] = 1; end
      end else begin
        if (df[i]) begin mbuf[i][0] = mbuf[i][1]; mcnt[i]--; end
        if (uf[i]) begin mbuf[i][mcnt[i]] = {pc, inst}; mcnt[i]++; mlast[i] = pc; end
      end
    end
  endtask

  initial begin
    rst = 1'b1; up_vld = 1'b0; flush = 1'b0; dn_rdy = 1'b0; up_pc = '0; up_inst = '0;
    for (int i = 0; i < 3; i++) begin mcnt[i] = 0; mlast[i] = '0; end
    @(posedge clk);
    step(1, 0, 0, 0, 0, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_pc%0d", i), 64'(dn_pc[i]), 64'h0);
      chk($sformatf("rst_inst%0d", i), 64'(dn_inst[i]), 64'h0);
      chk($sformatf("rst_rdy%0d", i), 64'(up_rdy[i]), 64'h1);
    end

    // streaming
    step(0, 1, 32'h1c000000, 32'h11, 0, 1);
    #1 chk("stream0", 64'(dn_pc[0]), 64'h1c000000);
    step(0, 1, 32'h1c000004, 32'h12, 0, 1);
    step(0, 1, 32'h1c000008, 32'h13, 0, 1);
    #1 chk("stream2", 64'(dn_pc[0]), 64'h1c000008);
    step(0, 0, 0, 0, 0, 1);

    // backpressure into the skid entry
    step(0, 1, 32'h1c000000, 32'h21, 0, 0);
    step(0, 1, 32'h1c000004, 32'h22, 0, 0);
    #1 chk("bp_occ", 64'(occ[0]), 64'h2);
    chk("bp_rdy", 64'(up_rdy[0]), 64'h0);
    step(0, 1, 32'h1c0000f0, 32'h23, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    #1 chk("bp_pc1", 64'(dn_pc[0]), 64'h1c000004);
    chk("bp_rdy1", 64'(up_rdy[0]), 64'h1);
    step(0, 0, 0, 0, 0, 1);

    // flush with bubble: last accepted 0x1c000010, concurrent 0x1c000014 is dropped
    step(0, 1, 32'h1c000010, 32'h31, 0, 0);
    step(0, 1, 32'h1c000014, 32'h32, 1, 0);
    #1 chk("fl_vld", 64'(dn_vld[0]), 64'h1);
    chk("fl_pc", 64'(dn_pc[0]), 64'h1c000010);
    chk("fl_inst", 64'(dn_inst[0]), 64'h03400000);
    chk("fl_occ", 64'(occ[0]), 64'h1);
    step(0, 0, 0, 0, 1, 0);
    #1 chk("fl2_pc", 64'(dn_pc[0]), 64'h1c000010);
    step(0, 0, 0, 0, 0, 1);

    // silent flush from a full variant
    step(0, 1, 32'h1c000020, 32'h41, 0, 0);
    step(0, 1, 32'h1c000024, 32'h42, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    #1 chk("nb_vld", 64'(dn_vld[1]), 64'h0);
    chk("nb_occ", 64'(occ[1]), 64'h0);
    chk("nb_rdy", 64'(up_rdy[1]), 64'h1);
    step(0, 0, 0, 0, 0, 1);

    // single-register replace in one cycle
    step(0, 1, 32'h1c000030, 32'h51, 0, 0);
    step(0, 1, 32'h1c000034, 32'h52, 0, 0);
    step(0, 1, 32'h1c000038, 32'h53, 0, 1);
    #1 chk("s0_pc", 64'(dn_pc[2]), 64'h1c000038);
    chk("s0_occ", 64'(occ[2]), 64'h1);
    step(0, 0, 0, 0, 0, 1);

    // reset during a full stall with flush asserted
    step(0, 1, 32'h1c000040, 32'h61, 0, 0);
    step(0, 1, 32'h1c000044, 32'h62, 0, 0);
    step(1, 1, 32'h1c000048, 32'h63, 1, 0);
    #1 chk("rs_occ", 64'(occ[0]), 64'h0);
    chk("rs_pc", 64'(dn_pc[0]), 64'h0);
    chk("rs_rdy", 64'(up_rdy[0]), 64'h1);
    step(0, 0, 0, 0, 1, 0);
    #1 chk("rs_bub", 64'(dn_pc[0]), 64'h0);
    chk("rs_bubv", 64'(dn_vld[0]), 64'h1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
           32'h1c000000 + {$urandom_range(0, 255), 2'b00}, $urandom,
           $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
